imem_loader: RTL



---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port used by the boot loader.
// The master side is the byte source and memory observer; the slave side is the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Stream: header N, 4*N payload bytes (little-endian words), XOR check byte.
// Words are written to consecutive addresses from 0; the core is held in
// reset until the whole image has been written and the check byte matches.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [6:0]          words_loaded
);
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [7:0]  checksum;
    logic [6:0]  n_words;
    logic [23:0] word_buf;   // lanes 0..2 of the word being assembled
    logic        xfer;

    assign xfer = bus.byte_valid & bus.byte_ready;

    // Loader FSM; every output is registered and updated together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            words_loaded   <= '0;
            byte_cnt       <= '0;
            checksum       <= '0;
            n_words        <= '0;
            word_buf       <= '0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data hold otherwise.
            bus.imem_we <= 1'b0;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state          <= HDR;
                        bus.byte_ready <= 1'b1;
                        done           <= 1'b0;
                        err            <= 1'b0;
                        words_loaded   <= '0;
                        checksum       <= '0;
                        bus.imem_waddr <= '0;
                        byte_cnt       <= '0;
                        cpu_hold       <= 1'b1;
                    end
                end

                HDR: begin
                    if (xfer) begin
                        if (bus.byte_in > DEPTH_B) begin
                            // Image larger than the memory: reject before writing anything.
                            state          <= ERR;
                            bus.byte_ready <= 1'b0;
                            err            <= 1'b1;
                        end else if (bus.byte_in == 8'd0) begin
                            state <= CHK;
                        end else begin
                            n_words <= bus.byte_in[6:0];
                            state   <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        checksum <= checksum ^ bus.byte_in;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bus.byte_in;
                            2'd1: word_buf[15:8]  <= bus.byte_in;
                            2'd2: word_buf[23:16] <= bus.byte_in;
                            default: begin
                                // Fourth byte completes the word; write it next cycle.
                                bus.imem_we    <= 1'b1;
                                bus.imem_wdata <= {bus.byte_in, word_buf};
                                bus.imem_waddr <= words_loaded[ADDR_W-1:0];
                                words_loaded   <= words_loaded + 7'd1;
                                if (words_loaded + 7'd1 == n_words) begin
                                    state <= CHK;
                                end
                            end
                        endcase
                    end
                end

                CHK: begin
                    if (xfer) begin
                        bus.byte_ready <= 1'b0;
                        if (bus.byte_in == checksum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state          <= IDLE;
                    bus.byte_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
